rr_arb2_stream: RTL and testbench

Two-input round-robin stream arbiter that merges two valid/ready sources into one registered output stream. Arbitration produces the select that steers the existing 2:1 mux bit-slices; the winning word is captured in a one-deep output register. Sits directly upstream of the mux datapath and replaces ad-hoc select generation with a fair, back-pressure-aware controller.

---
 rtl/rr_arb2_stream_pkg.sv | 19 +
 rtl/rr_arb2_stream_mux2_1.sv | 11 +
 rtl/rr_arb2_stream.sv | 64 ++++++
 tb/tb_rr_arb2_stream.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arb2_stream_pkg.sv
// Shared definitions for the two-input round-robin stream arbiter.
// Holds the grant function so the bench-facing RTL stays small.
package rr_arb2_stream_pkg;

  // Priority pointer value after reset: source 0 wins the first tie.
  localparam logic LAST_RESET = 1'b1;

  // Round-robin grant: on a tie the source opposite to the previous winner
  // wins. With no requester the grant holds at the previous winner.
  function automatic logic rr_grant(input logic v0, input logic v1, input logic last);
    logic g;
    g = last;
    if (v0 && v1)  g = ~last;
    else if (v0)   g = 1'b0;
    else if (v1)   g = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/rr_arb2_stream_mux2_1.sv
// One-bit 2:1 mux slice steered by the arbiter grant.
module mux2_1 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

// File: rtl/rr_arb2_stream.sv
// Two-input round-robin stream arbiter feeding a one-deep output register.
// The grant steers a bank of mux2_1 slices that select the winning word.
module rr_arb2_stream
  import rr_arb2_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             s,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  logic             last;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] mux_y;

  assign load_en = !out_valid || out_ready;
  assign s       = rr_grant(i0_valid, i1_valid, last);

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign i0_ready = !rst && load_en && i0_valid && (s == 1'b0);
  assign i1_ready = !rst && load_en && i1_valid && (s == 1'b1);
  assign xfer     = i0_ready || i1_ready;

  for (genvar k = 0; k < WIDTH; k++) begin : g_mux
    mux2_1 u_mux (
      .a (i0_data[k]),
      .b (i1_data[k]),
      .s (s),
      .y (mux_y[k])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      last      <= LAST_RESET;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= s;
      last      <= s;
    end else if (out_ready) begin
      // Drain with no refill: data and source are held for observability.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb2_stream.sv
// Directed bench for rr_arb2_stream: a reference model predicts grants and
// readies, and accepted words are queued and compared as they leave.
module tb_rr_arb2_stream;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i0_valid, i1_valid, out_ready;
  logic [WIDTH-1:0] i0_data, i1_data;
  logic             i0_ready, i1_ready, s, out_valid, out_src;
  logic [WIDTH-1:0] out_data;

  int errors = 0;
  int checks = 0;

  // Expected words in flight: {source, data}.
  logic [WIDTH:0] sb_q[$];
  logic           m_last;
  logic           m_valid;

  rr_arb2_stream #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .i0_valid  (i0_valid),
    .i0_data   (i0_data),
    .i0_ready  (i0_ready),
    .i1_valid  (i1_valid),
    .i1_data   (i1_data),
    .i1_ready  (i1_ready),
    .s         (s),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic logic model_grant(input logic v0, input logic v1, input logic lst);
    if (v0 && v1) return !lst;
    if (v0)       return 1'b0;
    if (v1)       return 1'b1;
    return lst;
  endfunction

  // Called just after a falling edge with inputs applied: checks the
  // combinational outputs and the registered word, then advances one cycle.
  task automatic cycle(input string tag);
    logic       e_load, e_s, e_r0, e_r1;
    logic [WIDTH:0] head;
    e_load = !m_valid || out_ready;
    e_s    = model_grant(i0_valid, i1_valid, m_last);
    e_r0   = e_load && i0_valid && !e_s;
    e_r1   = e_load && i1_valid && e_s;
    #1;
    check({tag, ".s"},        16'(s),        16'(e_s));
    check({tag, ".i0_ready"}, 16'(i0_ready), 16'(e_r0));
    check({tag, ".i1_ready"}, 16'(i1_ready), 16'(e_r1));
    check({tag, ".out_valid"}, 16'(out_valid), 16'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check({tag, ".sb_empty"}, 16'(sb_q.size()), 16'd1);
      end else begin
        head = sb_q[0];
        check({tag, ".out_data"}, 16'(out_data), 16'(head[WIDTH-1:0]));
        check({tag, ".out_src"},  16'(out_src),  16'(head[WIDTH]));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
    if (e_r0 || e_r1) begin
      sb_q.push_back({e_s, e_s ? i1_data : i0_data});
      m_last  = e_s;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    i0_valid  = 1'b0;
    i1_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 4 && (m_valid || sb_q.size() != 0); n++) cycle("drain");
    check("drain.empty", 16'(sb_q.size()), 16'd0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0;
    i0_valid = 1'b1; i1_valid = 1'b1;
    i0_data = 8'h11; i1_data = 8'h22;
    m_last = 1'b1; m_valid = 1'b0;

    // Reset held with both sources requesting.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", 16'(out_valid), 16'd0);
    check("rst.out_data",  16'(out_data),  16'd0);
    check("rst.out_src",   16'(out_src),   16'd0);
    check("rst.i0_ready",  16'(i0_ready),  16'd0);
    check("rst.i1_ready",  16'(i1_ready),  16'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // First tie goes to source 0, then strict alternation.
    cycle("first");
    check("first.win", 16'(sb_q[0]), {7'd0, 1'b0, 8'h11});
    for (int n = 0; n < 4; n++) cycle("fair");
    drain();

    // Back-pressure: load 0xA5 from source 0, stall 3 cycles with both valid.
    i0_valid = 1'b1; i0_data = 8'hA5;
    cycle("bp.load");
    i1_valid = 1'b1; i1_data = 8'h3C; i0_data = 8'h5A;
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle("bp.stall");
      check("bp.held", 16'(out_data), 16'h00A5);
    end
    out_ready = 1'b1;
    cycle("bp.release");
    check("bp.next_src1", 16'(sb_q[sb_q.size()-1]), {7'd0, 1'b1, 8'h3C});
    drain();

    // Single source 1, back-to-back.
    i0_valid = 1'b0; i1_valid = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      i1_data = 8'(n);
      cycle("single");
    end
    drain();

    // Drain without refill: one word, then idle; s must hold last winner.
    i0_valid = 1'b1; i0_data = 8'h77;
    cycle("solo.load");
    i0_valid = 1'b0;
    cycle("solo.drain");
    cycle("solo.idle");
    check("solo.s_hold", 16'(s), 16'd0);

    // Mid-stream asynchronous reset between edges.
    i0_valid = 1'b1; i1_valid = 1'b1; i0_data = 8'h44; i1_data = 8'h88;
    cycle("mid.load");
    check("mid.loaded", 16'(out_valid), 16'd1);
    #1 rst = 1'b1;
    #1;
    check("mid.out_valid", 16'(out_valid), 16'd0);
    check("mid.out_data",  16'(out_data),  16'd0);
    check("mid.i0_ready",  16'(i0_ready),  16'd0);
    check("mid.i1_ready",  16'(i1_ready),  16'd0);
    sb_q.delete();
    m_valid = 1'b0; m_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid.held_rdy", 16'(i0_ready | i1_ready), 16'd0);
    rst = 1'b0;
    cycle("mid.after");
    check("mid.tie_src0", 16'(sb_q[0]), {7'd0, 1'b0, 8'h44});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
